led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Sequences the iCEBreaker LED bank: PMOD LEDs LED1..LED5 (active-high) and on-board red/green (active-low, LEDR_N/LEDG_N).
- Runs one of four step patterns on LED1..LED5 at a prescaled step rate, under start/stop control.
- Drives the on-board LEDs with independent 8-bit PWM brightness.
- Sits between top-level board pins and any user logic that wants LED animation.

Parameters:
- CLK_HZ, 12000000, input clock frequency.
- STEP_HZ, 4, pattern step rate. DIV = CLK_HZ/STEP_HZ; must satisfy DIV >= 2.
- PWM_BITS, 8, PWM counter and duty width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle pulse; begins a run.
- stop  in  1  single-cycle pulse; ends a run at the next step boundary.
- mode  in  2  pattern select, latched at start: 0 chase, 1 bounce, 2 blink, 3 binary.
- red_duty  in  PWM_BITS  red brightness.
- green_duty  in  PWM_BITS  green brightness.
- busy  out  1  high while not IDLE.
- step_done  out  1  one-cycle pulse per pattern step.
- LEDR_N  out  1  red on-board LED, active-low.
- LEDG_N  out  1  green on-board LED, active-low.
- LED1..LED5  out  1 each  PMOD LEDs, active-high.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous, active-low. All outputs are registered.
- Reset values: LED1..5 = 0, LEDR_N = LEDG_N = 1, busy = 0, step_done = 0. Prescaler, pos, dir, phase, bin and pwm_cnt all = 0. State = IDLE.
- Reset asserted mid-run forces the reset values immediately.

States:
- IDLE, RUN, STOPPING.
- IDLE + start: latch mode, clear the prescaler, load the initial pattern, go to RUN. LEDs show the initial pattern on the next cycle. busy = 1 on the next cycle.
- RUN + stop: go to STOPPING.
- STOPPING: at the next tick, LED1..5 = 0, go to IDLE, busy = 0. No step_done pulse on that tick.
- start while busy: ignored. mode is not relatched.
- start and stop in the same cycle from IDLE: stop wins; stay IDLE.
- stop while IDLE: ignored.

Prescaler:
- Counts 0..DIV-1 and wraps.
- tick = (count == DIV-1).
- The first step advance occurs DIV cycles after the start cycle.

On a tick in RUN:
- Advance the pattern.
- Pulse step_done on the same edge the LEDs update.

Patterns (pos is 3-bit, range 0..4):
- chase: LED(pos+1) one-hot; pos 0→4, then wraps to 0. Initial pos = 0.
- bounce: one-hot with dir flag; sequence 0,1,2,3,4,3,2,1,0,1,... Reverse direction on reaching 4 or 0; no end repeats.
- blink: all five LEDs = phase; phase toggles each step. Initial phase = 1 (all on).
- binary: 5-bit counter bin, with LED1 = bin[0] ... LED5 = bin[4]. Increments each step; 31 wraps to 0. Initial value 0.

PWM:
- pwm_cnt is free-running PWM_BITS bits, independent of state.
- Duty is sampled into a shadow register when pwm_cnt == 0, so mid-period changes cause no glitch.
- Channel on when pwm_cnt < shadow_duty.
- Duty 0 → never on. Duty 255 → on 255 of every 256 cycles.
- LEDR_N = ~red_on, LEDG_N = ~green_on.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: shadow duty = (d*d) >> PWM_BITS. Examples: 16→1, 128→64, 255→254.
- Undefined: shadow duty = d (linear).

Decomposition:
- Package led_pkg holds:
  - mode enum: MODE_CHASE, MODE_BOUNCE, MODE_BLINK, MODE_BINARY.
  - state enum: ST_IDLE, ST_RUN, ST_STOPPING.
  - NUM_LEDS = 5.
  - gamma function, used under LED_GAMMA_EN.
- Sub-module led_pwm: counter compare plus duty shadow for one channel, instantiated twice. It takes the shared pwm_cnt or owns its own counter.

Test Plan (all with CLK_HZ=40, STEP_HZ=4, so DIV=10):
- Reset then idle 50 cycles → LED1..5 = 0, LEDR_N = LEDG_N = 1 while duty = 0, busy = 0, no step_done.
- start, mode=0 → LED1 on the next cycle. LED2 after 10 cycles, with step_done. Then LED3, LED4, LED5, then LED1 again at step 5.
- start, mode=1, run 10 steps → one-hot positions 1,2,3,4,3,2,1,0,1,2; no repeat at the ends.
- start, mode=3, run 32 steps → LED5..1 count 1..31, then 0. start pulsed mid-run is ignored.
- stop mid-run → busy stays 1 until the next tick, then LEDs 0 and busy 0. start+stop in the same cycle from IDLE → stays IDLE.
- red_duty=64, green_duty=255 → LEDR_N low 64 of 256 cycles, LEDG_N low 255 of 256. Changing duty mid-period takes effect at the next pwm_cnt==0. With LED_GAMMA_EN, red_duty=128 → low 64 of 256.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED sequencer.
//   mode_e   : step pattern selector (chase, bounce, blink, binary)
//   state_e  : sequencer control states
//   NUM_LEDS : number of PMOD LEDs driven by the pattern engine
//   gamma    : square-law brightness curve, used when LED_GAMMA_EN is defined
//   onehot   : position to one-hot LED vector
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int NUM_LEDS = 5;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BINARY = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    // Square-law duty mapping: (d*d) >> bits. Valid for bits <= 16.
    function automatic logic [31:0] gamma(input logic [31:0] d, input int unsigned bits);
        return (d * d) >> bits;
    endfunction

    // LED(pos+1) lit, all others dark.
    function automatic logic [NUM_LEDS-1:0] onehot(input logic [2:0] pos);
        return {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// ---------------------------------------------------------------------------
// led_pwm
// One PWM channel driving an active-low LED. The duty input is captured into
// a shadow register when the shared counter is zero, so a duty change made
// mid-period only takes effect from the next period.
// Optional build macro: LED_GAMMA_EN applies a square-law curve to the duty.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous reset, active-low
//   pwm_cnt  : shared free-running PWM counter
//   duty     : requested brightness
//   led_n    : registered active-low LED drive (1 = dark)
// ---------------------------------------------------------------------------
module led_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_n
);

    localparam logic [PWM_BITS-1:0] CNT_ZERO = {PWM_BITS{1'b0}};

    logic [PWM_BITS-1:0] shadow_r;
    logic [PWM_BITS-1:0] duty_eff_s;
    logic [PWM_BITS-1:0] thresh_s;
    logic                led_n_r;

    // Map the requested duty and pick the compare threshold for this cycle.
    always_comb begin
`ifdef LED_GAMMA_EN
        duty_eff_s = PWM_BITS'(gamma(32'(duty), PWM_BITS));
`else
        duty_eff_s = duty;
`endif
        // At the period start the freshly sampled duty already governs the
        // compare, so each period is on for exactly shadow_duty cycles.
        if (pwm_cnt == CNT_ZERO) begin
            thresh_s = duty_eff_s;
        end else begin
            thresh_s = shadow_r;
        end
    end

    // Duty shadow capture and registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= CNT_ZERO;
            led_n_r  <= 1'b1;
        end else begin
            if (pwm_cnt == CNT_ZERO) begin
                shadow_r <= duty_eff_s;
            end
            led_n_r <= ~(pwm_cnt < thresh_s);
        end
    end

    assign led_n = led_n_r;

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Step-pattern animation on PMOD LED1..LED5 plus PWM brightness on the
// on-board red/green LEDs of an iCEBreaker.
// Optional build macro: LED_GAMMA_EN (square-law PWM duty curve).
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   start, stop         : single-cycle run control pulses
//   mode                : pattern select, latched at start
//   red_duty/green_duty : on-board LED brightness
//   busy                : high while not idle
//   step_done           : one-cycle pulse per pattern step
//   LEDR_N, LEDG_N      : on-board LEDs, active-low
//   LED1..LED5          : PMOD LEDs, active-high
// ---------------------------------------------------------------------------
module led_sequencer
    import led_pkg::*;
#(
    parameter int CLK_HZ   = 12000000,
    parameter int STEP_HZ  = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] red_duty,
    input  logic [PWM_BITS-1:0] green_duty,
    output logic                busy,
    output logic                step_done,
    output logic                LEDR_N,
    output logic                LEDG_N,
    output logic                LED1,
    output logic                LED2,
    output logic                LED3,
    output logic                LED4,
    output logic                LED5
);

    localparam int DIV     = CLK_HZ / STEP_HZ;
    localparam int PRESC_W = $clog2(DIV);

    localparam logic [PRESC_W-1:0]  PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [NUM_LEDS-1:0] LEDS_OFF   = {NUM_LEDS{1'b0}};
    localparam logic [NUM_LEDS-1:0] BIN_ONE    = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS-1:0] PWM_ZERO   = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_ONE    = {{(PWM_BITS-1){1'b0}}, 1'b1};

    state_e              state_r,  state_s;
    mode_e               mode_r,   mode_s;
    logic [PRESC_W-1:0]  presc_r,  presc_s;
    logic [2:0]          pos_r,    pos_s;
    logic                dir_r,    dir_s;     // 0 = towards LED5, 1 = towards LED1
    logic                phase_r,  phase_s;
    logic [NUM_LEDS-1:0] bin_r,    bin_s;
    logic [NUM_LEDS-1:0] leds_r,   leds_s;
    logic                step_done_r, step_done_s;
    logic                busy_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic                tick_s;

    // LED vector for a given pattern state.
    function automatic logic [NUM_LEDS-1:0] render(input mode_e m, input logic [2:0] p,
                                                   input logic ph, input logic [NUM_LEDS-1:0] b);
        logic [NUM_LEDS-1:0] v;
        case (m)
            MODE_CHASE:  v = onehot(p);
            MODE_BOUNCE: v = onehot(p);
            MODE_BLINK:  v = {NUM_LEDS{ph}};
            MODE_BINARY: v = b;
            default:     v = LEDS_OFF;
        endcase
        return v;
    endfunction

    assign tick_s = (presc_r == PRESC_LAST);

    // Next-state, pattern advance and prescaler logic.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        pos_s       = pos_r;
        dir_s       = dir_r;
        phase_s     = phase_r;
        bin_s       = bin_r;
        leds_s      = leds_r;
        step_done_s = 1'b0;
        if (tick_s) begin
            presc_s = PRESC_ZERO;
        end else begin
            presc_s = presc_r + PRESC_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                // stop takes priority over a simultaneous start
                if (start && !stop) begin
                    mode_s  = mode_e'(mode);
                    presc_s = PRESC_ZERO;
                    pos_s   = 3'd0;
                    dir_s   = 1'b0;
                    phase_s = 1'b1;
                    bin_s   = LEDS_OFF;
                    leds_s  = render(mode_e'(mode), 3'd0, 1'b1, LEDS_OFF);
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_s) begin
                    step_done_s = 1'b1;
                    case (mode_r)
                        MODE_CHASE: begin
                            if (pos_r == 3'd4) begin
                                pos_s = 3'd0;
                            end else begin
                                pos_s = pos_r + 3'd1;
                            end
                        end
                        MODE_BOUNCE: begin
                            // turn around at the ends without repeating them
                            if (!dir_r) begin
                                if (pos_r == 3'd4) begin
                                    dir_s = 1'b1;
                                    pos_s = 3'd3;
                                end else begin
                                    pos_s = pos_r + 3'd1;
                                end
                            end else begin
                                if (pos_r == 3'd0) begin
                                    dir_s = 1'b0;
                                    pos_s = 3'd1;
                                end else begin
                                    pos_s = pos_r - 3'd1;
                                end
                            end
                        end
                        MODE_BLINK:  phase_s = ~phase_r;
                        MODE_BINARY: bin_s   = bin_r + BIN_ONE;
                        default:     pos_s   = pos_r;
                    endcase
                    leds_s = render(mode_r, pos_s, phase_s, bin_s);
                end else begin
                    leds_s = leds_r;
                end
                if (stop) begin
                    state_s = ST_STOPPING;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (tick_s) begin
                    leds_s  = LEDS_OFF;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOPPING;
                end
            end
            default: begin
                leds_s  = LEDS_OFF;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered pattern outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_CHASE;
            presc_r     <= PRESC_ZERO;
            pos_r       <= 3'd0;
            dir_r       <= 1'b0;
            phase_r     <= 1'b0;
            bin_r       <= LEDS_OFF;
            leds_r      <= LEDS_OFF;
            step_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            presc_r     <= presc_s;
            pos_r       <= pos_s;
            dir_r       <= dir_s;
            phase_r     <= phase_s;
            bin_r       <= bin_s;
            leds_r      <= leds_s;
            step_done_r <= step_done_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Free-running PWM counter shared by both channels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_cnt_r <= PWM_ZERO;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
        end
    end

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_red (
        .clk     (CLK),
        .rst_n   (RST_N),
        .pwm_cnt (pwm_cnt_r),
        .duty    (red_duty),
        .led_n   (LEDR_N)
    );

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_green (
        .clk     (CLK),
        .rst_n   (RST_N),
        .pwm_cnt (pwm_cnt_r),
        .duty    (green_duty),
        .led_n   (LEDG_N)
    );

    assign busy      = busy_r;
    assign step_done = step_done_r;
    assign LED1      = leds_r[0];
    assign LED2      = leds_r[1];
    assign LED3      = leds_r[2];
    assign LED4      = leds_r[3];
    assign LED5      = leds_r[4];

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
// Randomized scoreboard bench for led_sequencer with CLK_HZ=40, STEP_HZ=4.
// Pattern expectations are queued when a run starts and popped on each
// step_done; PWM expectations are queued at each period start and popped
// when the period's low-cycle count is complete.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int DIV = 10;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] red_duty = 8'd0;
    logic [7:0] green_duty = 8'd0;
    logic       busy, step_done, LEDR_N, LEDG_N;
    logic       LED1, LED2, LED3, LED4, LED5;
    logic [4:0] leds_v;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int red_q[$];
    int grn_q[$];
    logic [7:0] tcnt;

    assign leds_v = {LED5, LED4, LED3, LED2, LED1};

    led_sequencer #(.CLK_HZ(40), .STEP_HZ(4), .PWM_BITS(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .mode(mode),
        .red_duty(red_duty), .green_duty(green_duty), .busy(busy),
        .step_done(step_done), .LEDR_N(LEDR_N), .LEDG_N(LEDG_N),
        .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected LED1..5 vector (bit0 = LED1) for step n of a pattern.
    function automatic int exp_leds(input int m, input int n);
        int p;
        case (m)
            0: return 1 << (n % 5);
            1: begin
                p = n % 8;
                if (p > 4) p = 8 - p;
                return 1 << p;
            end
            2: return ((n % 2) == 0) ? 31 : 0;
            default: return n % 32;
        endcase
    endfunction

    function automatic int exp_low(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    // PWM reference: period boundary every 256 cycles after reset release.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt <= 8'd0;
            red_q.delete();
            grn_q.delete();
        end else begin
            if (tcnt == 8'd0) begin
                red_q.push_back(exp_low(int'(red_duty)));
                grn_q.push_back(exp_low(int'(green_duty)));
            end
            tcnt <= tcnt + 8'd1;
        end
    end

    // PWM monitor: count low cycles per period and compare with the queue.
    initial begin
        int racc, gacc;
        bit started;
        logic [7:0] phase;
        racc = 0; gacc = 0; started = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                racc = 0; gacc = 0; started = 1'b0;
            end else begin
                phase = tcnt - 8'd1;
                if (phase == 8'd0) started = 1'b1;
                if (started) begin
                    if (!LEDR_N) racc++;
                    if (!LEDG_N) gacc++;
                    if (phase == 8'd255) begin
                        if (red_q.size() > 0 && grn_q.size() > 0) begin
                            check("pwm_red_low", racc, red_q.pop_front());
                            check("pwm_green_low", gacc, grn_q.pop_front());
                        end else begin
                            check("pwm_queue_size", red_q.size(), 1);
                        end
                        racc = 0; gacc = 0;
                    end
                end
            end
        end
    end

    // Step monitor: pop expected LED vector and check step spacing.
    initial begin
        int cyc, last_evt;
        logic busy_prev;
        cyc = 0; last_evt = 0; busy_prev = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (busy && !busy_prev) last_evt = cyc;
            if (step_done) begin
                check("step_interval", cyc - last_evt, DIV);
                last_evt = cyc;
                check("step_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("step_leds", int'(leds_v), exp_q.pop_front());
            end
            busy_prev = busy;
        end
    end

    // Start a run, let nsteps steps pass, then stop and check the wind-down.
    task automatic run_pattern(input int m, input int nsteps, input bit inject);
        int seen, bound, k, bad;
        @(negedge CLK);
        mode = 2'(m);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        mode = 2'($urandom);
        for (int n = 1; n <= nsteps; n++) exp_q.push_back(exp_leds(m, n));
        check("initial_leds", int'(leds_v), exp_leds(m, 0));
        check("busy_after_start", int'(busy), 1);
        seen = 0;
        bound = (nsteps + 2) * DIV;
        for (int i = 0; i < bound && seen < nsteps; i++) begin
            if (inject && i == 15) begin
                start = 1'b1;
                mode = 2'(m ^ 1);
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            if (step_done) seen++;
        end
        start = 1'b0;
        check("steps_within_budget", seen, nsteps);
        k = $urandom_range(0, 8);
        repeat (k) @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        check("busy_while_stopping", int'(busy), 1);
        bad = 0;
        repeat (8 - k) begin
            @(negedge CLK);
            if (busy !== 1'b1 || step_done !== 1'b0) bad++;
        end
        check("stopping_hold", bad, 0);
        @(negedge CLK);
        check("busy_after_stop", int'(busy), 0);
        check("leds_after_stop", int'(leds_v), 0);
        check("no_step_on_stop", int'(step_done), 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        // reset values
        #23;
        check("rst_leds", int'(leds_v), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_ledr_n", int'(LEDR_N), 1);
        check("rst_ledg_n", int'(LEDG_N), 1);
        @(posedge CLK); #2;
        RST_N = 1'b1;

        // idle for 50 cycles
        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (leds_v !== 5'd0 || busy !== 1'b0 || step_done !== 1'b0 ||
                LEDR_N !== 1'b1 || LEDG_N !== 1'b1) bad++;
        end
        check("idle_quiet", bad, 0);

        run_pattern(0, 5, 1'b0);   // chase, wraps back to LED1
        run_pattern(1, 10, 1'b0);  // bounce
        run_pattern(2, 3, 1'b0);   // blink
        run_pattern(3, 32, 1'b1);  // binary with ignored start mid-run
        repeat (2) run_pattern(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 1'(($urandom) & 1));

        // start and stop together from idle, and stop alone while idle
        @(negedge CLK);
        start = 1'b1; stop = 1'b1;
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        check("start_stop_leds", int'(leds_v), 0);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        bad = 0;
        repeat (25) begin
            @(negedge CLK);
            if (busy !== 1'b0 || leds_v !== 5'd0) bad++;
        end
        check("idle_after_start_stop", bad, 0);

        // PWM: fixed duties, then random mid-period changes
        red_duty = 8'd64; green_duty = 8'd255;
        repeat (600) @(negedge CLK);
        red_duty = 8'd128; green_duty = 8'd0;
        repeat (300) @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(50, 300)) @(negedge CLK);
            red_duty = 8'($urandom);
            green_duty = 8'($urandom);
        end
        repeat (520) @(negedge CLK);

        // reset asserted mid-run
        @(negedge CLK);
        mode = 2'd0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int n = 1; n <= 5; n++) exp_q.push_back(exp_leds(0, n));
        repeat (24) @(negedge CLK);
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_leds", int'(leds_v), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_step_done", int'(step_done), 0);
        check("midrst_ledr_n", int'(LEDR_N), 1);
        check("midrst_ledg_n", int'(LEDG_N), 1);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        run_pattern(1, 6, 1'b0);
        repeat (300) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
